// File: rtl/viterbi_stream_decoder.sv
// ----------------------------------------------------------------------------
// viterbi_stream_decoder
//
// Hard-decision Viterbi decoder for rate-1/R convolutional codes with
// constraint length K. A block of L received symbols is accepted over a
// valid/ready stream. Each accepted symbol triggers one add-compare-select
// step across all 2^(K-1) trellis states. The decoder then traces back L
// steps through register-based survivor memory. Finally it presents the
// decoded block together with the path metric of the traceback start state.
//
// Ports:
//   clk        - clock
//   rst        - asynchronous active-low reset
//   sync_clr   - synchronous abort; returns to symbol acceptance with
//                freshly initialised metrics and cleared outputs
//   sym_in     - received code bits, sym_in[j] pairs with generator j
//   sym_valid  - sym_in valid
//   sym_ready  - decoder is accepting symbols
//   msg_out    - decoded bits, first received symbol's bit in msg_out[L-1]
//   metric_out - path metric of the traceback start state
//   out_valid  - msg_out/metric_out valid
//   out_ready  - consumer accepts the decoded block
// ----------------------------------------------------------------------------
module viterbi_stream_decoder #(
   parameter int             R    = 2,
   parameter int             K    = 3,
   parameter logic [R*K-1:0] G    = {3'b101, 3'b111},
   parameter int             L    = 5,
   parameter int             PMW  = 8,
   parameter bit             TERM = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           sync_clr,
   input  logic [R-1:0]   sym_in,
   input  logic           sym_valid,
   output logic           sym_ready,
   output logic [L-1:0]   msg_out,
   output logic [PMW-1:0] metric_out,
   output logic           out_valid,
   input  logic           out_ready
);

   localparam int SW  = K - 1;
   localparam int NS  = 1 << SW;
   localparam int TW  = (L > 1) ? $clog2(L) : 1;
   localparam int BMW = $clog2(R + 1);
   localparam logic [TW-1:0] T_LAST = TW'(L - 1);

   typedef enum logic [1:0] {
      ST_ACCEPT,
      ST_TRACE,
      ST_DONE
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [TW-1:0]   t_q;
   logic [SW-1:0]   tb_state_q;
   logic [PMW-1:0]  pm_q    [NS];
   logic [PMW-1:0]  pm_next [NS];
   logic [NS-1:0]   dec_q   [L];
   logic [NS-1:0]   dec_next;
   logic [SW-1:0]   ns_v;
   logic [SW-1:0]   p0_v;
   logic [SW-1:0]   p1_v;
   logic [PMW-1:0]  cand0;
   logic [PMW-1:0]  cand1;
   logic [SW-1:0]   best_idx;
   logic [PMW-1:0]  best_pm;
   logic [SW-1:0]   cur_state;

   // Expected encoder output for a full encoder register {input, state}.
   function automatic logic [R-1:0] code_bits(input logic [K-1:0] reg_val);
      logic [R-1:0] c;
      for (int j = 0; j < R; j++) begin
         c[j] = ^(reg_val & G[j*K +: K]);
      end
      return c;
   endfunction

   // Number of set bits in a received-vs-expected difference word.
   function automatic logic [BMW-1:0] hamming(input logic [R-1:0] x);
      logic [BMW-1:0] n;
      n = '0;
      for (int j = 0; j < R; j++) begin
         n = n + BMW'(x[j]);
      end
      return n;
   endfunction

   // Metric addition that sticks at all-ones so unreachable states stay worst.
   function automatic logic [PMW-1:0] sat_add(input logic [PMW-1:0] a,
                                              input logic [BMW-1:0] b);
      logic [PMW:0] s;
      s = {1'b0, a} + {{(PMW + 1 - BMW){1'b0}}, b};
      return s[PMW] ? '1 : s[PMW-1:0];
   endfunction

   // Add-compare-select for every next state. The two predecessors differ
   // only in their oldest bit. A tie keeps the predecessor whose oldest bit is 0.
   always_comb begin
      for (int i = 0; i < NS; i++) begin
         pm_next[i] = '0;
      end
      dec_next = '0;
      ns_v     = '0;
      p0_v     = '0;
      p1_v     = '0;
      cand0    = '0;
      cand1    = '0;
      for (int i = 0; i < NS; i++) begin
         ns_v  = SW'(i);
         p0_v  = {ns_v[SW-2:0], 1'b0};
         p1_v  = {ns_v[SW-2:0], 1'b1};
         cand0 = sat_add(pm_q[p0_v], hamming(sym_in ^ code_bits({ns_v[SW-1], p0_v})));
         cand1 = sat_add(pm_q[p1_v], hamming(sym_in ^ code_bits({ns_v[SW-1], p1_v})));
         if (cand1 < cand0) begin
            pm_next[i]  = cand1;
            dec_next[i] = 1'b1;
         end else begin
            pm_next[i]  = cand0;
         end
      end
   end

   // Traceback start state: state 0 for a terminated trellis, otherwise
   // the lowest-index state holding the smallest metric.
   always_comb begin
      best_idx = '0;
      best_pm  = pm_q[0];
      if (TERM == 1'b0) begin
         for (int i = 1; i < NS; i++) begin
            if (pm_q[i] < best_pm) begin
               best_pm  = pm_q[i];
               best_idx = SW'(i);
            end
         end
      end
   end

   // The first traceback cycle starts from the selected state. Later
   // cycles follow the registered traceback state.
   always_comb begin
      cur_state = (t_q == T_LAST) ? best_idx : tb_state_q;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_ACCEPT;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and handshake outputs. The handshake outputs come
   // straight from the state. sync_clr overrides every transition.
   always_comb begin
      state_d   = state_q;
      sym_ready = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_ACCEPT: begin
            sym_ready = 1'b1;
            if (sym_valid && (t_q == T_LAST)) begin
               state_d = ST_TRACE;
            end
         end
         ST_TRACE: begin
            if (t_q == '0) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_ACCEPT;
            end
         end
         default: begin
            state_d = ST_ACCEPT;
         end
      endcase
      if (sync_clr) begin
         state_d = ST_ACCEPT;
      end
   end

   // Datapath: metrics, survivor decisions, step counter and traceback.
   // The step counter stays at L-1 after the last accepted symbol, so the
   // traceback counts down from there without reloading.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         t_q        <= '0;
         tb_state_q <= '0;
         msg_out    <= '0;
         metric_out <= '0;
         for (int i = 0; i < NS; i++) begin
            pm_q[i] <= '1;
         end
         pm_q[0] <= '0;
         for (int i = 0; i < L; i++) begin
            dec_q[i] <= '0;
         end
      end else if (sync_clr) begin
         t_q        <= '0;
         msg_out    <= '0;
         metric_out <= '0;
         for (int i = 0; i < NS; i++) begin
            pm_q[i] <= '1;
         end
         pm_q[0] <= '0;
      end else begin
         case (state_q)
            ST_ACCEPT: begin
               if (sym_valid) begin
                  for (int i = 0; i < NS; i++) begin
                     pm_q[i] <= pm_next[i];
                  end
                  dec_q[t_q] <= dec_next;
                  if (t_q != T_LAST) begin
                     t_q <= t_q + 1'b1;
                  end
               end
            end
            ST_TRACE: begin
               msg_out[T_LAST - t_q] <= cur_state[SW-1];
               tb_state_q            <= {cur_state[SW-2:0], dec_q[t_q][cur_state]};
               if (t_q == T_LAST) begin
                  metric_out <= best_pm;
               end
               if (t_q != '0) begin
                  t_q <= t_q - 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  t_q <= '0;
                  for (int i = 0; i < NS; i++) begin
                     pm_q[i] <= '1;
                  end
                  pm_q[0] <= '0;
               end
            end
            default: begin
               t_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_stream_decoder.sv
// ----------------------------------------------------------------------------
// tb_viterbi_stream_decoder
//
// Drives two decoders from the same stimulus: one with free traceback and
// one with a terminated trellis. Expected results come from an exhaustive
// maximum-likelihood search over all 2^L messages of the K=3 (7,5) code.
// The handshake protocol is tracked by a small phase model.
// ----------------------------------------------------------------------------
module tb_viterbi_stream_decoder;

   localparam int L = 5;
   localparam logic [2*L-1:0] BLK_A = 10'b10_10_00_01_11;
   localparam logic [2*L-1:0] BLK_C = 10'b10_10_00_01_10;
   localparam logic [2*L-1:0] BLK_T = 10'b11_01_00_01_11;

   typedef struct packed {
      logic [L-1:0] msg;
      logic [7:0]   metric;
      logic         uniq;
   } result_t;

   typedef enum {M_ACCEPT, M_TRACE, M_DONE} mphase_t;

   logic       clk;
   logic       rst;
   logic       sync_clr;
   logic [1:0] sym_in;
   logic       sym_valid;
   logic       out_ready;
   logic       sym_ready0, sym_ready1;
   logic       out_valid0, out_valid1;
   logic [L-1:0] msg_out0, msg_out1;
   logic [7:0]   metric_out0, metric_out1;

   int checks = 0;
   int errors = 0;

   mphase_t        m_phase = M_ACCEPT;
   int             m_acc   = 0;
   int             m_wait  = 0;
   logic           m_zero  = 1'b1;
   logic [2*L-1:0] m_blk   = '0;
   result_t        m_res0  = '0;
   result_t        m_res1  = '0;

   viterbi_stream_decoder #(.R(2), .K(3), .G({3'b101, 3'b111}), .L(L), .PMW(8), .TERM(1'b0)) dut0 (
      .clk(clk), .rst(rst), .sync_clr(sync_clr), .sym_in(sym_in), .sym_valid(sym_valid),
      .sym_ready(sym_ready0), .msg_out(msg_out0), .metric_out(metric_out0),
      .out_valid(out_valid0), .out_ready(out_ready));

   viterbi_stream_decoder #(.R(2), .K(3), .G({3'b101, 3'b111}), .L(L), .PMW(8), .TERM(1'b1)) dut1 (
      .clk(clk), .rst(rst), .sync_clr(sync_clr), .sym_in(sym_in), .sym_valid(sym_valid),
      .sym_ready(sym_ready1), .msg_out(msg_out1), .metric_out(metric_out1),
      .out_valid(out_valid1), .out_ready(out_ready));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exhaustive ML decode: encode every candidate message with the textbook
   // (7,5) shift-register equations and keep the closest one. With term set,
   // only messages ending in K-1 zeros are considered.
   function automatic result_t bruteForce(input logic [2*L-1:0] blk, input bit term);
      result_t      r;
      int           best;
      int           nbest;
      int           d;
      logic [L+1:0] hist;
      logic         b0, b1, b2;
      logic [1:0]   c;
      logic [1:0]   rx;
      r     = '0;
      best  = 1 << 30;
      nbest = 0;
      for (int v = 0; v < (1 << L); v++) begin
         hist = {2'b00, L'(v)};
         if (term && hist[1:0] != 2'b00) continue;
         d = 0;
         for (int t = 0; t < L; t++) begin
            b0   = hist[L-1-t];
            b1   = hist[L-t];
            b2   = hist[L+1-t];
            c[0] = b0 ^ b1 ^ b2;
            c[1] = b0 ^ b2;
            rx   = blk[2*t +: 2];
            d    = d + int'(c[0] != rx[0]) + int'(c[1] != rx[1]);
         end
         if (d < best) begin
            best  = d;
            nbest = 1;
            r.msg = hist[L-1:0];
         end else if (d == best) begin
            nbest++;
         end
      end
      r.metric = 8'(best);
      r.uniq   = (nbest == 1);
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Send one block of L symbols with 'gap' idle cycles between symbols.
   // Returns at the falling edge right after the last symbol was accepted.
   task automatic applyStimulus(input logic [2*L-1:0] blk, input int gap);
      for (int t = 0; t < L; t++) begin
         @(negedge clk);
         sym_in    = blk[2*t +: 2];
         sym_valid = 1'b1;
         if (gap > 0 && t < L - 1) begin
            @(negedge clk);
            sym_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
         end
      end
      @(negedge clk);
      sym_valid = 1'b0;
   endtask

   task automatic waitValid(output int lat);
      lat = 0;
      while (out_valid0 !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic releaseOutput();
      @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("ready_after_release", 32'(sym_ready0), 32'd1);
   endtask

   // Protocol phase model: counts accepted symbols, waits L edges for the
   // traceback, then holds the ML result until the output handshake.
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst || sync_clr) begin
            m_phase = M_ACCEPT;
            m_acc   = 0;
            m_zero  = 1'b1;
         end else begin
            case (m_phase)
               M_ACCEPT: begin
                  if (sym_valid) begin
                     m_blk[2*m_acc +: 2] = sym_in;
                     m_acc++;
                     if (m_acc == L) begin
                        m_phase = M_TRACE;
                        m_wait  = 0;
                        m_zero  = 1'b0;
                     end
                  end
               end
               M_TRACE: begin
                  m_wait++;
                  if (m_wait == L) begin
                     m_phase = M_DONE;
                     m_res0  = bruteForce(m_blk, 1'b0);
                     m_res1  = bruteForce(m_blk, 1'b1);
                  end
               end
               default: begin
                  if (out_ready) begin
                     m_phase = M_ACCEPT;
                     m_acc   = 0;
                  end
               end
            endcase
         end
      end
   end

   // Per-cycle comparison of both decoders against the model.
   initial begin
      forever begin
         @(negedge clk);
         checkOutput("sym_ready0", 32'(sym_ready0), 32'(m_phase == M_ACCEPT));
         checkOutput("sym_ready1", 32'(sym_ready1), 32'(m_phase == M_ACCEPT));
         checkOutput("out_valid0", 32'(out_valid0), 32'(m_phase == M_DONE));
         checkOutput("out_valid1", 32'(out_valid1), 32'(m_phase == M_DONE));
         if (m_phase == M_DONE) begin
            checkOutput("metric0", 32'(metric_out0), 32'(m_res0.metric));
            checkOutput("metric1", 32'(metric_out1), 32'(m_res1.metric));
            if (m_res0.uniq) checkOutput("msg0", 32'(msg_out0), 32'(m_res0.msg));
            if (m_res1.uniq) checkOutput("msg1", 32'(msg_out1), 32'(m_res1.msg));
         end
         if (m_zero) begin
            checkOutput("zero_msg0", 32'(msg_out0), 32'd0);
            checkOutput("zero_metric0", 32'(metric_out0), 32'd0);
            checkOutput("zero_msg1", 32'(msg_out1), 32'd0);
         end
      end
   end

   // Watchdog so a stuck run still terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed test sequence.
   initial begin
      result_t r;
      int      lat;
      rst       = 1'b0;
      sync_clr  = 1'b0;
      sym_in    = 2'b00;
      sym_valid = 1'b0;
      out_ready = 1'b0;

      // Pin the reference search against hand-derived results.
      r = bruteForce(BLK_A, 1'b0);
      checkOutput("model_a_msg", 32'(r.msg), 32'b10110);
      checkOutput("model_a_metric", 32'(r.metric), 32'd0);
      r = bruteForce(BLK_C, 1'b0);
      checkOutput("model_c_msg", 32'(r.msg), 32'b10110);
      checkOutput("model_c_metric", 32'(r.metric), 32'd1);
      r = bruteForce(BLK_T, 1'b1);
      checkOutput("model_t_msg", 32'(r.msg), 32'b10100);
      checkOutput("model_t_metric", 32'(r.metric), 32'd0);

      repeat (3) @(negedge clk);
      checkOutput("reset_out_valid", 32'(out_valid0), 32'd0);
      checkOutput("reset_msg", 32'(msg_out0), 32'd0);
      checkOutput("reset_metric", 32'(metric_out0), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("reset_sym_ready", 32'(sym_ready0), 32'd1);

      // Clean block, back-to-back, with an exact latency check.
      applyStimulus(BLK_A, 0);
      waitValid(lat);
      checkOutput("latency_a", 32'(lat), 32'd5);
      checkOutput("a_msg", 32'(msg_out0), 32'b10110);
      checkOutput("a_metric", 32'(metric_out0), 32'd0);

      // Stall in DONE while symbols are offered.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         sym_valid = 1'b1;
         sym_in    = 2'b11;
         checkOutput("stall_valid", 32'(out_valid0), 32'd1);
         checkOutput("stall_msg", 32'(msg_out0), 32'b10110);
         checkOutput("stall_ready", 32'(sym_ready0), 32'd0);
      end
      sym_valid = 1'b0;
      releaseOutput();

      // Corrupted first symbol, decoded from fresh metrics.
      applyStimulus(BLK_C, 0);
      waitValid(lat);
      checkOutput("latency_c", 32'(lat), 32'd5);
      checkOutput("c_msg", 32'(msg_out0), 32'b10110);
      checkOutput("c_metric", 32'(metric_out0), 32'd1);
      releaseOutput();

      // Terminated message 101 + two tail zeros.
      applyStimulus(BLK_T, 0);
      waitValid(lat);
      checkOutput("t_msg1", 32'(msg_out1), 32'b10100);
      checkOutput("t_metric1", 32'(metric_out1), 32'd0);
      checkOutput("t_msg0", 32'(msg_out0), 32'b10100);
      releaseOutput();

      // Gapped symbols give the same result.
      applyStimulus(BLK_A, 2);
      waitValid(lat);
      checkOutput("latency_gap", 32'(lat), 32'd5);
      checkOutput("gap_msg", 32'(msg_out0), 32'b10110);
      checkOutput("gap_metric", 32'(metric_out0), 32'd0);
      releaseOutput();

      // Asynchronous reset in the middle of the traceback.
      applyStimulus(BLK_A, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      checkOutput("rst_trace_valid", 32'(out_valid0), 32'd0);
      checkOutput("rst_trace_msg", 32'(msg_out0), 32'd0);
      checkOutput("rst_trace_metric", 32'(metric_out0), 32'd0);
      checkOutput("rst_trace_ready", 32'(sym_ready0), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      applyStimulus(BLK_A, 0);
      waitValid(lat);
      checkOutput("post_rst_msg", 32'(msg_out0), 32'b10110);
      checkOutput("post_rst_metric", 32'(metric_out0), 32'd0);
      releaseOutput();

      // Synchronous abort after three symbols; the symbol offered with it is dropped.
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         sym_in    = BLK_C[2*t +: 2];
         sym_valid = 1'b1;
      end
      @(negedge clk);
      sync_clr  = 1'b1;
      sym_in    = 2'b11;
      @(negedge clk);
      sync_clr  = 1'b0;
      sym_valid = 1'b0;
      checkOutput("clr_ready", 32'(sym_ready0), 32'd1);
      checkOutput("clr_msg", 32'(msg_out0), 32'd0);
      checkOutput("clr_metric", 32'(metric_out0), 32'd0);
      applyStimulus(BLK_A, 0);
      waitValid(lat);
      checkOutput("latency_clr", 32'(lat), 32'd5);
      checkOutput("post_clr_msg", 32'(msg_out0), 32'b10110);
      checkOutput("post_clr_metric", 32'(metric_out0), 32'd0);
      releaseOutput();

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/viterbi_stream_decoder.md
Name: viterbi_stream_decoder

Overview:
Parametrised hard-decision Viterbi decoder for rate-1/R convolutional codes with arbitrary constraint length K and generator set. It accepts a block of L received symbols over a valid/ready stream and performs one add-compare-select (ACS) step per accepted symbol across all 2^(K-1) states. It then traces back through on-chip survivor memory and presents the decoded L-bit block with its final path metric on a valid/ready output. This block replaces fixed K=3/R=2 decoders in the codec datapath.

Parameters:
R, 2, code bits per symbol (>=1)
K, 3, constraint length (>=3); NS = 2^(K-1) states
G, {3'b101,3'b111}, R*K-bit generator pack; generator j = G[j*K +: K]
L, 5, symbols (decoded bits) per block
PMW, 8, path-metric width; must satisfy 2^(PMW-1) > L*R
TERM, 0, 1 = trellis terminated, traceback from state 0; 0 = traceback from minimum-metric state

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
sync_clr  in  1  synchronous abort: return to ACCEPT with metrics reinitialised
sym_in  in  R  received code bits; sym_in[j] corresponds to generator j
sym_valid  in  1  sym_in valid
sym_ready  out  1  decoder can accept a symbol
msg_out  out  L  decoded bits; first-received symbol's bit in msg_out[L-1]
metric_out  out  PMW  path metric of the traceback start state (Hamming errors corrected)
out_valid  out  1  msg_out/metric_out valid
out_ready  in  1  consumer accepts output

Behaviour:
- Trellis: state s has K-1 bits. Input b gives encoder register {b,s}, code bit j = XOR of ({b,s} & G_j), and next state ns = {b, s[K-2:1]}.
- Predecessors of ns: p0 = {ns[K-3:0],0} and p1 = {ns[K-3:0],1}. Branch metric = Hamming distance (0..R) between sym_in and the expected bits.
- ACS: candidate = PM[p] + BM, saturating at 2^PMW-1. Select p1 only if strictly smaller; a tie selects p0. Decision bit d[t][ns] = 1 if p1 is selected.
- Survivor memory: L x NS decision bits, registers only.
- Metric init (reset, sync_clr, or out handshake): PM[0] = 0, all other states = all-ones.
- FSM states and transitions:
  - ACCEPT: sym_ready=1. Each sym_valid&sym_ready edge performs one ACS step, stores decisions for step t, and increments t. After step L-1 is accepted, go to TRACE.
  - TRACE: sym_ready=0. On entry, select the start state: state 0 if TERM=1; otherwise the lowest-index state with the minimum PM. Latch its PM into metric_out. Each cycle processes one step, from t=L-1 down to t=0. msg_out[L-1-t] = tb_state[K-2] (the MSB, i.e. the input bit). The next tb_state = {tb_state[K-3:0], d[t][tb_state]}. Runs exactly L cycles.
  - DONE: out_valid=1, with msg_out and metric_out held stable. On out_valid&out_ready, clear out_valid, reinit metrics, reset t=0, and go to ACCEPT. sym_ready stays 0 until ACCEPT, so there is no overlap between blocks.
- Latency: out_valid rises exactly L clock edges after the edge that accepted the last symbol.
- sync_clr has priority over all transitions in every state. It clears out_valid, msg_out and metric_out. Any symbol presented in the same cycle is dropped.
- Reset values (asynchronous, mid-operation included): FSM=ACCEPT, t=0, sym_ready=1 after reset release, out_valid=0, msg_out=0, metric_out=0, metrics initialised, decisions=0.
- sym_valid while sym_ready=0 is ignored. out_ready while out_valid=0 has no effect.

Test Plan:
- Defaults, TERM=0, symbols 11,01,00,10,10 back-to-back -> msg_out=5'b10110, metric_out=0, out_valid exactly 5 edges after the last accept.
- Same block with the first symbol corrupted to 10 -> msg_out=5'b10110, metric_out=1.
- TERM=1, symbols 11,01,00,01,11 (message 101 + two tail zeros) -> msg_out=5'b10100, metric_out=0; a start state other than 0 is never used.
- out_ready held low 20 cycles in DONE -> out_valid and outputs stable, sym_ready=0 and offered symbols not consumed. Release -> ACCEPT next cycle; the second block decodes correctly from fresh metrics.
- sym_valid gapped (idle cycles between symbols) -> same result as back-to-back.
- rst asserted during TRACE, and sync_clr asserted after 3 symbols -> all outputs return to reset values; a following clean block decodes to 5'b10110.
